// File: rtl/register_file_32x32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : register_file_32x32
//  Description : 32-entry register array. It has one write port addressed by a
//                one-hot select and two read ports with binary addresses.
//                Read data is registered. A write or clear that hits the
//                address being read on the same edge bypasses into the read
//                data. A built-in sequencer clears the array, zeroing one
//                entry per cycle over 32 cycles. A write whose select is not
//                one-hot is rejected and pulses sel_err for one cycle.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      asynchronous active-low reset
//    wr_en      in   1      write request
//    wr_sel     in   32     one-hot write select, bit i selects register i
//    wr_data    in   WIDTH  write data
//    rd_addr_a  in   5      read address, port A
//    rd_addr_b  in   5      read address, port B
//    rd_data_a  out  WIDTH  registered read data, port A
//    rd_data_b  out  WIDTH  registered read data, port B
//    clr_req    in   1      start a full-array clear (honoured in IDLE only)
//    busy       out  1      clear sequence in progress
//    sel_err    out  1      one-cycle pulse after a rejected write
// ============================================================================
module register_file_32x32 #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [31:0]      wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [4:0]       rd_addr_a,
    input  logic [4:0]       rd_addr_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             sel_err
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_CLEAR    = 1'b1;
    localparam logic [4:0]  C_LAST_IDX = 5'd31;
    // When register 0 is hard-wired, its write strobe is masked off. A one-hot
    // write to it is still a legal select and is simply dropped.
    localparam logic [31:0] C_WR_MASK  = (ZERO_REG != 0) ? 32'hFFFF_FFFE
                                                         : 32'hFFFF_FFFF;

    logic [0:0]       r_state;
    logic [4:0]       r_clr_cnt;
    logic             r_sel_err;
    logic [WIDTH-1:0] r_regs [32];
    logic [WIDTH-1:0] r_rd_data_a;
    logic [WIDTH-1:0] r_rd_data_b;

    logic             w_idle;
    logic             w_sel_onehot;
    logic             w_wr_valid;
    logic [31:0]      w_wr_hit;
    logic [31:0]      w_clr_hit;
    logic [WIDTH-1:0] w_rd_next_a;
    logic [WIDTH-1:0] w_rd_next_b;

    assign w_idle = (r_state == S_IDLE);

    // A non-zero vector is one-hot when clearing its lowest set bit leaves
    // nothing behind.
    assign w_sel_onehot = (wr_sel != 32'd0) &&
                          ((wr_sel & (wr_sel - 32'd1)) == 32'd0);
    assign w_wr_valid   = w_idle && wr_en && w_sel_onehot;

    // Per-register strobes. Because the write strobe is the one-hot select
    // itself, each read port can test bypass with a single bit lookup, and no
    // encoder is needed.
    assign w_wr_hit  = w_wr_valid ? (wr_sel & C_WR_MASK) : 32'd0;
    assign w_clr_hit = (r_state == S_CLEAR) ? (32'd1 << r_clr_cnt) : 32'd0;

    // Read-data next value: stored content, then same-edge write bypass, then
    // same-edge clear bypass. Write and clear never coincide, because writes
    // are accepted only in IDLE.
    always_comb begin
        w_rd_next_a = r_regs[rd_addr_a];
        if (w_wr_hit[rd_addr_a]) begin
            w_rd_next_a = wr_data;
        end
        if (w_clr_hit[rd_addr_a]) begin
            w_rd_next_a = '0;
        end
        if ((ZERO_REG != 0) && (rd_addr_a == 5'd0)) begin
            w_rd_next_a = '0;
        end
    end

    always_comb begin
        w_rd_next_b = r_regs[rd_addr_b];
        if (w_wr_hit[rd_addr_b]) begin
            w_rd_next_b = wr_data;
        end
        if (w_clr_hit[rd_addr_b]) begin
            w_rd_next_b = '0;
        end
        if ((ZERO_REG != 0) && (rd_addr_b == 5'd0)) begin
            w_rd_next_b = '0;
        end
    end

    // Register array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (w_clr_hit[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wr_hit[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
        end else begin
            r_rd_data_a <= w_rd_next_a;
            r_rd_data_b <= w_rd_next_b;
        end
    end

    // Clear sequencer and select-error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_clr_cnt <= 5'd0;
            r_sel_err <= 1'b0;
        end else begin
            // A request is rejected only when it is seen in IDLE.
            r_sel_err <= w_idle && wr_en && !w_sel_onehot;
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state   <= S_CLEAR;
                        r_clr_cnt <= 5'd0;
                    end
                end
                S_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 5'd1;
                    if (r_clr_cnt == C_LAST_IDX) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // busy is decoded straight from the state register, so it drops together
    // with an asynchronous reset.
    assign busy      = (r_state == S_CLEAR);
    assign sel_err   = r_sel_err;
    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;

endmodule
`default_nettype wire

// File: tb/tb_register_file_32x32.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_32x32
//  Description : Self-checking bench for register_file_32x32. Two instances
//                share all stimulus. dut0 uses ZERO_REG=0 and dut1 uses
//                ZERO_REG=1. A behavioural array model predicts every output.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_32x32;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] wr_sel;
    logic [31:0] wr_data;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        clr_req;
    logic [31:0] rd_a0, rd_b0, rd_a1, rd_b1;
    logic        busy0, busy1, err0, err1;

    int n_total = 0;
    int n_pass  = 0;

    register_file_32x32 #(.WIDTH(32), .ZERO_REG(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .rd_addr_a(ra), .rd_addr_b(rb),
        .rd_data_a(rd_a0), .rd_data_b(rd_b0), .clr_req(clr_req),
        .busy(busy0), .sel_err(err0)
    );

    register_file_32x32 #(.WIDTH(32), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_data(wr_data), .rd_addr_a(ra), .rd_addr_b(rb),
        .rd_data_a(rd_a1), .rd_data_b(rd_b1), .clr_req(clr_req),
        .busy(busy1), .sel_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    // Index 0 models ZERO_REG=0 and index 1 models ZERO_REG=1.
    logic [31:0] m_reg [2][32];
    logic [31:0] m_rda [2];
    logic [31:0] m_rdb [2];
    logic        m_busy;
    int          m_cnt;
    logic        m_err;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) m_reg[d][r] = 32'd0;
            m_rda[d] = 32'd0;
            m_rdb[d] = 32'd0;
        end
        m_busy = 1'b0;
        m_cnt  = 0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] model_read(int d, int addr, logic valid,
                                               int idx);
        logic [31:0] v;
        v = m_reg[d][addr];
        if (valid && idx == addr) v = wr_data;
        if (m_busy && m_cnt == addr) v = 32'd0;
        if (d == 1 && addr == 0) v = 32'd0;
        return v;
    endfunction

    // Advance the model by one clock edge, using the inputs currently driven.
    task automatic model_step();
        int   ones;
        int   idx;
        logic valid;
        ones = $countones(wr_sel);
        idx  = 0;
        for (int i = 0; i < 32; i++) if (wr_sel[i]) idx = i;
        valid = !m_busy && wr_en && (ones == 1);
        for (int d = 0; d < 2; d++) begin
            m_rda[d] = model_read(d, int'(ra), valid, idx);
            m_rdb[d] = model_read(d, int'(rb), valid, idx);
        end
        m_err = !m_busy && wr_en && (ones != 1);
        if (valid) begin
            m_reg[0][idx] = wr_data;
            if (idx != 0) m_reg[1][idx] = wr_data;
        end
        if (m_busy) begin
            m_reg[0][m_cnt] = 32'd0;
            m_reg[1][m_cnt] = 32'd0;
            if (m_cnt == 31) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % 32;
        end else if (clr_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic compare_all(string tag);
        check({tag, "/rd_a0"}, rd_a0, m_rda[0]);
        check({tag, "/rd_b0"}, rd_b0, m_rdb[0]);
        check({tag, "/rd_a1"}, rd_a1, m_rda[1]);
        check({tag, "/rd_b1"}, rd_b1, m_rdb[1]);
        check({tag, "/busy0"}, {31'd0, busy0}, {31'd0, m_busy});
        check({tag, "/busy1"}, {31'd0, busy1}, {31'd0, m_busy});
        check({tag, "/err0"},  {31'd0, err0},  {31'd0, m_err});
        check({tag, "/err1"},  {31'd0, err1},  {31'd0, m_err});
    endtask

    // One clock: predict, let the edge happen, sample 1 ns later.
    task automatic tick(string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_sel = 32'd0; wr_data = 32'd0; clr_req = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] sel;
        logic [31:0] data;
        logic [4:0]  a;
        logic [4:0]  b;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        eerr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int busy_cycles;
        int r;

        // Expected values for dut0 (ZERO_REG=0), assuming reg[i] = A5A5_0000+i.
        tbl[0]  = '{1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 5'd7,  5'd8,  32'hDEAD_BEEF, 32'hA5A5_0008, 1'b0};
        tbl[1]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd7,  5'd7,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b1};
        tbl[3]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b0};
        tbl[4]  = '{1'b1, 32'h0000_0018, 32'h2222_2222, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b1};
        tbl[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b0};
        tbl[6]  = '{1'b1, 32'h0000_0018, 32'h3333_3333, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b1};
        tbl[7]  = '{1'b1, 32'hFFFF_FFFF, 32'h4444_4444, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b1};
        tbl[8]  = '{1'b0, 32'h0000_0018, 32'h5555_5555, 5'd3,  5'd4,  32'hA5A5_0003, 32'hA5A5_0004, 1'b0};
        tbl[9]  = '{1'b1, 32'h8000_0000, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'hA5A5_001E, 1'b0};
        tbl[10] = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 5'd31, 5'd31, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
        tbl[11] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 5'd31, 5'd0,  32'h0BAD_F00D, 32'hA5A5_0000, 1'b0};

        // ---- reset ----
        rst_n = 1'b0;
        idle_inputs();
        ra = 5'd0; rb = 5'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        rst_n = 1'b1;

        // ---- write pattern, then read back on both ports ----
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_sel = 32'd1 << i; wr_data = 32'hA5A5_0000 + i;
            ra = 5'(i); rb = 5'(31 - i);
            tick("wrpat");
        end
        idle_inputs();
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            tick("rdback");
            check("rdback/const_a0", rd_a0, 32'hA5A5_0000 + i);
            check("rdback/const_b0", rd_b0, 32'hA5A5_0000 + (31 - i));
        end

        // ---- table-driven directed vectors ----
        for (int i = 0; i < 12; i++) begin
            wr_en = tbl[i].we; wr_sel = tbl[i].sel; wr_data = tbl[i].data;
            ra = tbl[i].a; rb = tbl[i].b;
            tick("tbl");
            check("tbl/ea", rd_a0, tbl[i].ea);
            check("tbl/eb", rd_b0, tbl[i].eb);
            check("tbl/eerr", {31'd0, err0}, {31'd0, tbl[i].eerr});
        end
        idle_inputs();

        // ---- ZERO_REG behaviour ----
        wr_en = 1'b1; wr_sel = 32'h0000_0001; wr_data = 32'h1234_5678;
        ra = 5'd0; rb = 5'd0;
        tick("zr_w0");
        check("zr_w0/bypass_a1", rd_a1, 32'h0);
        check("zr_w0/err1", {31'd0, err1}, 32'd0);
        idle_inputs();
        tick("zr_r0");
        check("zr_r0/a1", rd_a1, 32'h0);
        check("zr_r0/a0", rd_a0, 32'h1234_5678);
        wr_en = 1'b1; wr_sel = 32'h0000_0002; wr_data = 32'h1234_5678;
        ra = 5'd1; rb = 5'd0;
        tick("zr_w1");
        idle_inputs();
        tick("zr_r1");
        check("zr_r1/a1", rd_a1, 32'h1234_5678);
        check("zr_r1/b1", rd_b1, 32'h0);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 9));
            wr_en = ($urandom_range(0, 3) != 0);
            if (r < 7)       wr_sel = 32'd1 << $urandom_range(0, 31);
            else if (r == 7) wr_sel = 32'd0;
            else             wr_sel = $urandom;
            wr_data = $urandom;
            ra = 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 4) == 0) ? ra : 5'($urandom_range(0, 31));
            clr_req = ($urandom_range(0, 59) == 0);
            tick("rand");
        end
        idle_inputs();
        for (int n = 0; n < 40 && m_busy; n++) tick("drain");

        // ---- clear: preload all-ones, then clear; write during busy ignored ----
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_sel = 32'd1 << i; wr_data = 32'hFFFF_FFFF;
            ra = 5'(i); rb = 5'((i + 1) % 32);
            tick("preload");
        end
        idle_inputs();
        clr_req = 1'b1;
        tick("clr_start");
        clr_req = 1'b0;
        busy_cycles = 0;
        while (busy0 && busy_cycles < 40) begin
            busy_cycles++;
            if (busy_cycles == 1) begin
                wr_en = 1'b1; wr_sel = 32'h0000_0020; wr_data = 32'h0BAD_0005;
            end else begin
                wr_en = 1'b0; wr_sel = 32'd0;
            end
            clr_req = (busy_cycles == 5);
            ra = 5'($urandom_range(0, 31));
            rb = 5'($urandom_range(0, 31));
            tick("clearing");
            check("clearing/err0", {31'd0, err0}, 32'd0);
        end
        idle_inputs();
        check("clear/busy_cycles", busy_cycles, 32);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            tick("postclr");
            check("postclr/a0", rd_a0, 32'd0);
            check("postclr/b0", rd_b0, 32'd0);
        end

        // ---- asynchronous reset in the middle of a clear ----
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_sel = 32'd1 << i; wr_data = 32'h5A5A_0000 + i;
            tick("reload");
        end
        idle_inputs();
        clr_req = 1'b1;
        tick("mid_start");
        clr_req = 1'b0;
        ra = 5'd20; rb = 5'd25;
        for (int i = 0; i < 10; i++) tick("mid_run");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst/busy0", {31'd0, busy0}, 32'd0);
        check("midrst/busy1", {31'd0, busy1}, 32'd0);
        check("midrst/rd_a0", rd_a0, 32'd0);
        check("midrst/rd_b0", rd_b0, 32'd0);
        check("midrst/err0", {31'd0, err0}, 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ra = 5'd25; rb = 5'd20;
        tick("after_rst");
        check("after_rst/reg25", rd_a0, 32'd0);
        wr_en = 1'b1; wr_sel = 32'd1 << 20; wr_data = 32'h2020_2020;
        ra = 5'd20;
        tick("r20_w");
        idle_inputs();
        tick("r20_r");
        check("r20/a0", rd_a0, 32'h2020_2020);
        check("r20/b0", rd_b0, 32'h2020_2020);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- Register array of 32 × WIDTH bits, directly downstream of the 5-bit address decoder.
- Write port takes the decoder's 32-bit one-hot select unchanged.
- Two read ports use binary 5-bit addresses, with registered read data and same-cycle write bypass.
- A built-in clear sequencer zeroes the array one entry per cycle. It flags malformed (non-one-hot) write selects.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ZERO_REG, 0, when 1 register 0 always reads as 0 and writes to it are discarded (no error raised).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- WR_EN  input  1  write request, sampled on CLK rise.
- WR_SEL  input  32  one-hot write select from the decoder; bit i selects register i.
- WR_DATA  input  WIDTH  write data.
- RD_ADDR_A  input  5  read address, port A.
- RD_ADDR_B  input  5  read address, port B.
- RD_DATA_A  output  WIDTH  registered read data, port A.
- RD_DATA_B  output  WIDTH  registered read data, port B.
- CLR_REQ  input  1  request to clear the whole array, sampled in IDLE only.
- BUSY  output  1  high while the clear sequence runs.
- SEL_ERR  output  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (RST_N low, asynchronous):
  - all 32 registers = 0.
  - RD_DATA_A, RD_DATA_B = 0.
  - BUSY = 0, SEL_ERR = 0.
  - state = IDLE, clear counter = 0.
- Release of reset is synchronous to CLK. The first active edge after RST_N rises is a normal cycle.
- State machine:
  - IDLE: accepts writes and reads. If CLR_REQ = 1 on an edge, go to CLEAR. In the same edge, counter = 0 and BUSY = 1.
  - CLEAR: each edge zeroes register[counter] and increments counter (5-bit).
    - On the edge where counter = 31, register 31 is zeroed, the state returns to IDLE and BUSY = 0.
    - BUSY is therefore high for exactly 32 cycles.
    - CLR_REQ is ignored in CLEAR.
    - WR_EN is ignored in CLEAR: no write and no SEL_ERR.
  - Reset mid-CLEAR: the array goes to 0 anyway; state = IDLE, BUSY = 0.
- Write (IDLE only):
  - If WR_EN = 1 and WR_SEL has exactly one bit set, register[i] <= WR_DATA at the edge.
  - If WR_EN = 1 and WR_SEL is all-zero or has 2 or more bits set, no register changes and SEL_ERR = 1 for the following cycle only.
  - WR_EN = 0: WR_SEL is don't-care and no error is raised.
  - SEL_ERR returns to 0 on the next edge unless another rejected write occurs.
- Read:
  - RD_DATA_x <= register[RD_ADDR_x] at each edge (1-cycle latency), in IDLE and CLEAR.
  - Bypass: if a valid write in the same edge targets RD_ADDR_x, RD_DATA_x <= WR_DATA (new data, not old).
  - Both ports may read the same address; both see identical data.
  - Read during CLEAR returns the pre-edge array content. A register being zeroed on that same edge returns 0 (clear bypass).
- ZERO_REG = 1:
  - register 0 is constant 0.
  - A one-hot write to bit 0 is silently dropped; SEL_ERR stays 0.
  - Reads of address 0 return 0, including any bypass case.
- Writes to the same register on consecutive edges: last write wins. Each read reflects the array state after the previous edge, plus bypass.

Test Plan:
- Reset, then write pattern: RST_N = 0 for 3 cycles then 1. Write 0xA5A5_0000+i to each register via WR_SEL = 1<<i for i = 0..31. Read back all 32 on both ports -> each RD_DATA equals 0xA5A5_0000+i exactly one cycle after the address is applied. BUSY = 0 and SEL_ERR = 0 throughout.
- Bypass: RD_ADDR_A = 7 and WR_EN = 1, WR_SEL = 0x0000_0080, WR_DATA = 0xDEAD_BEEF, all in the same cycle -> RD_DATA_A = 0xDEAD_BEEF on the next cycle. Port B reading address 8 shows its old value.
- Malformed select:
  - WR_EN = 1, WR_SEL = 0x0000_0000 -> SEL_ERR high for exactly 1 cycle, array unchanged.
  - Repeat with WR_SEL = 0x0000_0018 -> same response; registers 3 and 4 keep their prior values.
- Clear:
  - Preload all registers with 0xFFFF_FFFF, then pulse CLR_REQ -> BUSY high for exactly 32 cycles. All reads afterwards = 0.
  - A write to register 5 issued during BUSY is ignored: reads 0 after the clear, SEL_ERR stays 0.
- Reset mid-clear: assert RST_N = 0 asynchronously at clear cycle 10 -> BUSY and RD_DATA drop to 0 immediately without waiting for CLK. After release, a write and read of register 20 works normally.
- ZERO_REG = 1: write 0x1234_5678 with WR_SEL = 0x0000_0001, then read address 0 -> 0, SEL_ERR = 0. The same write to register 1 reads back 0x1234_5678.
